// File: rtl/fdd_track_cache.sv
`default_nettype none
// fdd_track_cache: write-back single-track floppy cache between the disk controller and an SD block channel.
// Optional: define FDD_IDLE_FLUSH_EN to write dirty sectors back after IDLE_CYCLES without a controller write.
module fdd_track_cache #(
  parameter int SECTORS     = 13,
  parameter int TRACK_W     = 6,
  parameter int IDLE_CYCLES = 1000000
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_size_nz,
  input  logic               img_readonly,
  input  logic [12:0]        fd_addr,
  input  logic               fd_we,
  input  logic [7:0]         fd_din,
  output logic [7:0]         fd_dout,
  output logic               cpu_wait,
  output logic               dirty,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din
);
  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd1;
  localparam logic [2:0] S_FLUSH_REQ  = 3'd2;
  localparam logic [2:0] S_FLUSH_XFER = 3'd3;
  localparam logic [2:0] S_LOAD_REQ   = 3'd4;
  localparam logic [2:0] S_LOAD_XFER  = 3'd5;
  localparam int          LBA_W       = TRACK_W + 4;
  localparam logic [12:0] TRACK_BYTES = 13'(SECTORS * 512);

  logic [2:0]         state_q, state_d;
  logic [TRACK_W-1:0] cur_track_q, cur_track_d;
  logic               mounted_q, mounted_d, ro_q, ro_d, valid_q, valid_d;
  logic [SECTORS-1:0] mask_q, mask_d, mask_set;
  logic [3:0]         sector_q, sector_d;
  logic               pend_q, pend_d, pend_size_q, pend_size_d, pend_ro_q, pend_ro_d;
  logic               idle_flush_q, idle_flush_d;
  logic               ack_q, rd_q, wr_q, cpu_wait_q;
  logic [7:0]         fd_dout_q, buff_din_q;
  logic [LBA_W-1:0]   lba;
  logic               fd_wr_ok, ack_rise, ack_fall, idle_start;
  logic [12:0]        ram_a_addr;
  logic [7:0]         mem [0:8191];

  assign fd_wr_ok   = (state_q == S_IDLE) && fd_we && (fd_addr < TRACK_BYTES);
  assign mask_set   = (fd_wr_ok && !ro_q) ? ({{(SECTORS-1){1'b0}}, 1'b1} << fd_addr[12:9]) : '0;
  assign ack_rise   = sd_ack && !ack_q;
  assign ack_fall   = !sd_ack && ack_q;
  assign lba        = LBA_W'(cur_track_q) * LBA_W'(SECTORS) + LBA_W'(sector_q);
  assign ram_a_addr = {sector_q, sd_buff_addr};

  assign sd_lba      = 32'(lba);
  assign sd_rd       = rd_q;
  assign sd_wr       = wr_q;
  assign cpu_wait    = cpu_wait_q;
  assign dirty       = |mask_q;
  assign fd_dout     = fd_dout_q;
  assign sd_buff_din = buff_din_q;

`ifdef FDD_IDLE_FLUSH_EN
  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) idle_cnt_q <= '0;
    else if (state_q != S_IDLE || !mounted_q || mask_q == '0 || fd_wr_ok) idle_cnt_q <= '0;
    else if (!idle_start) idle_cnt_q <= idle_cnt_q + CNT_W'(1);
  end

  assign idle_start = (state_q == S_IDLE) && mounted_q && (mask_q != '0) &&
                      (idle_cnt_q == CNT_W'(IDLE_CYCLES));
`else
  logic unused_idle_cycles;
  assign unused_idle_cycles = (IDLE_CYCLES != 0);
  assign idle_start         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cur_track_d  = cur_track_q;
    mounted_d    = mounted_q;
    ro_d         = ro_q;
    valid_d      = valid_q;
    sector_d     = sector_q;
    idle_flush_d = idle_flush_q;
    mask_d       = mask_q | mask_set;
    pend_d       = pend_q;
    pend_size_d  = pend_size_q;
    pend_ro_d    = pend_ro_q;
    // A mount seen while busy is parked until the current operation returns to IDLE.
    if (img_mounted && state_q != S_IDLE) begin
      pend_d      = 1'b1;
      pend_size_d = img_size_nz;
      pend_ro_d   = img_readonly;
    end
    case (state_q)
      S_IDLE: begin
        idle_flush_d = 1'b0;
        if (img_mounted || pend_q) begin
          pend_d    = 1'b0;
          mounted_d = img_mounted ? img_size_nz : pend_size_q;
          ro_d      = img_mounted ? img_readonly : pend_ro_q;
          mask_d    = '0;
          valid_d   = 1'b0;
          if (mounted_d) begin
            state_d     = S_LOAD_REQ;
            cur_track_d = track;
            sector_d    = '0;
          end
        end else if (mounted_q && (track != cur_track_q || !valid_q)) begin
          if (mask_d != '0) begin
            state_d = S_FLUSH_SCAN;
          end else begin
            state_d     = S_LOAD_REQ;
            cur_track_d = track;
            sector_d    = '0;
            valid_d     = 1'b0;
          end
        end else if (idle_start) begin
          state_d      = S_FLUSH_SCAN;
          idle_flush_d = 1'b1;
        end else if (!mounted_q) begin
          cur_track_d = track;
        end
      end
      S_FLUSH_SCAN: begin
        if (mask_q != '0) begin
          for (int i = SECTORS - 1; i >= 0; i--) begin
            if (mask_q[i]) sector_d = 4'(i);
          end
          state_d = S_FLUSH_REQ;
        end else if (idle_flush_q) begin
          state_d = S_IDLE;
        end else begin
          state_d     = S_LOAD_REQ;
          cur_track_d = track;
          sector_d    = '0;
          valid_d     = 1'b0;
        end
      end
      S_FLUSH_REQ:  if (ack_rise) state_d = S_FLUSH_XFER;
      S_FLUSH_XFER: begin
        if (ack_fall) begin
          mask_d  = mask_q & ~({{(SECTORS-1){1'b0}}, 1'b1} << sector_q);
          state_d = S_FLUSH_SCAN;
        end
      end
      S_LOAD_REQ:   if (ack_rise) state_d = S_LOAD_XFER;
      S_LOAD_XFER: begin
        if (ack_fall) begin
          if (sector_q == 4'(SECTORS - 1)) begin
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            sector_d = sector_q + 4'd1;
            state_d  = S_LOAD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_track_q  <= '0;
      mounted_q    <= 1'b0;
      ro_q         <= 1'b0;
      valid_q      <= 1'b0;
      mask_q       <= '0;
      sector_q     <= '0;
      pend_q       <= 1'b0;
      pend_size_q  <= 1'b0;
      pend_ro_q    <= 1'b0;
      idle_flush_q <= 1'b0;
      ack_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      cpu_wait_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_track_q  <= cur_track_d;
      mounted_q    <= mounted_d;
      ro_q         <= ro_d;
      valid_q      <= valid_d;
      mask_q       <= mask_d;
      sector_q     <= sector_d;
      pend_q       <= pend_d;
      pend_size_q  <= pend_size_d;
      pend_ro_q    <= pend_ro_d;
      idle_flush_q <= idle_flush_d;
      ack_q        <= sd_ack;
      rd_q         <= (state_d == S_LOAD_REQ);
      wr_q         <= (state_d == S_FLUSH_REQ);
      cpu_wait_q   <= (state_d != S_IDLE);
    end
  end

  // Port A serves the SD channel, port B the controller; their writes never coincide.
  always_ff @(posedge clk_sys) begin
    if (state_q == S_LOAD_XFER && sd_ack && sd_buff_wr) mem[ram_a_addr] <= sd_buff_dout;
    if (fd_wr_ok) mem[fd_addr] <= fd_din;
    buff_din_q <= mem[ram_a_addr];
    fd_dout_q  <= mem[fd_addr];
  end
endmodule
`default_nettype wire

// File: tb/tb_fdd_track_cache.sv
`default_nettype none
// Self-checking bench for fdd_track_cache: an HPS block-channel model checks each SD request
// against a scoreboard of expected requests pushed as the stimulus is applied.
module tb_fdd_track_cache;
  localparam int SECTORS     = 13;
  localparam int TRACK_W     = 6;
  localparam int IDLE_CYCLES = 100;
  localparam int REQ_LIMIT   = 3000;

  logic               clk_sys = 1'b0;
  logic               reset_n;
  logic [TRACK_W-1:0] track;
  logic               img_mounted, img_size_nz, img_readonly;
  logic [12:0]        fd_addr;
  logic               fd_we;
  logic [7:0]         fd_din, fd_dout;
  logic               cpu_wait, dirty;
  logic [31:0]        sd_lba;
  logic               sd_rd, sd_wr, sd_ack;
  logic [8:0]         sd_buff_addr;
  logic [7:0]         sd_buff_dout, sd_buff_din;
  logic               sd_buff_wr;

  fdd_track_cache #(.SECTORS(SECTORS), .TRACK_W(TRACK_W), .IDLE_CYCLES(IDLE_CYCLES)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
    .img_mounted(img_mounted), .img_size_nz(img_size_nz), .img_readonly(img_readonly),
    .fd_addr(fd_addr), .fd_we(fd_we), .fd_din(fd_din), .fd_dout(fd_dout),
    .cpu_wait(cpu_wait), .dirty(dirty), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit         wr;
    int         lba;
    int         poff;
    logic [7:0] pval;
  } req_t;

  req_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] blk [0:511];

  function automatic logic [7:0] img_byte(input int lba, input int i);
    return 8'((lba * 37 + i * 5 + (i >> 4)) & 255);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_rd_range(input int first, input int last);
    for (int l = first; l <= last; l++) sb_q.push_back('{wr: 1'b0, lba: l, poff: 0, pval: 8'h00});
  endtask

  task automatic push_wr(input int lba, input int poff, input logic [7:0] pval);
    sb_q.push_back('{wr: 1'b1, lba: lba, poff: poff, pval: pval});
  endtask

  task automatic mount(input logic nz, input logic ro);
    img_size_nz  = nz;
    img_readonly = ro;
    img_mounted  = 1'b1;
    @(negedge clk_sys);
    img_mounted  = 1'b0;
  endtask

  task automatic fd_write(input int addr, input logic [7:0] val);
    fd_addr = 13'(addr);
    fd_din  = val;
    fd_we   = 1'b1;
    @(negedge clk_sys);
    fd_we   = 1'b0;
  endtask

  task automatic fd_check(input string tag, input int addr, input logic [7:0] exp);
    fd_addr = 13'(addr);
    @(negedge clk_sys);
    check_eq(tag, 32'(fd_dout), 32'(exp));
  endtask

  // Plays the HPS side for nreq requests, checking each against the scoreboard head.
  task automatic hps_serve(input int nreq);
    for (int r = 0; r < nreq; r++) begin
      req_t e;
      int   t;
      int   errs;
      t = 0;
      errs = 0;
      while (!(sd_rd || sd_wr) && t < REQ_LIMIT) begin
        @(negedge clk_sys);
        t++;
      end
      check_eq("req_seen", 32'(t < REQ_LIMIT), 32'd1);
      if (t >= REQ_LIMIT) return;
      check_eq("req_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() == 0) return;
      e = sb_q.pop_front();
      check_eq("req_kind", {30'd0, sd_wr, sd_rd}, e.wr ? 32'd2 : 32'd1);
      check_eq("req_lba", sd_lba, 32'(e.lba));
      check_eq("req_wait", 32'(cpu_wait), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      check_eq("req_drop", {30'd0, sd_wr, sd_rd}, 32'd0);
      for (int i = 0; i < 512; i++) begin
        sd_buff_addr = 9'(i);
        if (!e.wr) begin
          sd_buff_dout = img_byte(e.lba, i);
          sd_buff_wr   = 1'b1;
        end
        @(negedge clk_sys);
        if (e.wr) blk[i] = sd_buff_din;
      end
      sd_buff_wr = 1'b0;
      sd_ack     = 1'b0;
      if (e.wr) begin
        for (int i = 0; i < 512; i++)
          if (i != e.poff && blk[i] !== img_byte(e.lba, i)) errs++;
        check_eq("flush_data", 32'(errs), 32'd0);
        check_eq("flush_patch", 32'(blk[e.poff]), 32'(e.pval));
      end
      @(negedge clk_sys);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int cnt;
    int n_pre;
    reset_n = 1'b0; track = '0; img_mounted = 1'b0; img_size_nz = 1'b0; img_readonly = 1'b0;
    fd_addr = '0; fd_we = 1'b0; fd_din = '0; sd_ack = 1'b0; sd_buff_addr = '0;
    sd_buff_dout = '0; sd_buff_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check_eq("rst_lba", sd_lba, 32'd0);
    check_eq("rst_rd", 32'(sd_rd), 32'd0);
    check_eq("rst_wr", 32'(sd_wr), 32'd0);
    check_eq("rst_wait", 32'(cpu_wait), 32'd0);
    check_eq("rst_dirty", 32'(dirty), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // Mount at track 0: full-track load of blocks 0..12.
    push_rd_range(0, 12);
    mount(1'b1, 1'b0);
    check_eq("mount_wait", 32'(cpu_wait), 32'd1);
    hps_serve(13);
    check_eq("load0_wait_low", 32'(cpu_wait), 32'd0);
    check_eq("load0_sb_empty", 32'(sb_q.size()), 32'd0);
    for (int k = 0; k < SECTORS; k++) fd_check("load0_first_byte", 512 * k, img_byte(k, 0));
    fd_check("load0_mid_byte", 512 * 3 + 77, img_byte(3, 77));

    // Clean track change 0 -> 5.
    push_rd_range(65, 77);
    track = 6'd5;
    hps_serve(13);
    check_eq("trk5_sb_empty", 32'(sb_q.size()), 32'd0);
    check_eq("trk5_dirty", 32'(dirty), 32'd0);
    fd_check("trk5_byte", 13'h0203, img_byte(66, 3));

    // Dirty sectors 1 and 12, then move to track 6.
    fd_write(13'h0203, 8'hA5);
    fd_write(13'h1801, 8'h5A);
    check_eq("write_dirty", 32'(dirty), 32'd1);
    fd_check("write_readback", 13'h0203, 8'hA5);
    push_wr(66, 3, 8'hA5);
    push_wr(77, 1, 8'h5A);
    push_rd_range(78, 90);
    track = 6'd6;
    hps_serve(15);
    check_eq("flush_dirty_clear", 32'(dirty), 32'd0);
    check_eq("trk6_sb_empty", 32'(sb_q.size()), 32'd0);
    fd_check("trk6_byte", 13'h0203, img_byte(79, 3));

    // Read-only image: writes land in RAM but never mark dirty.
    push_rd_range(78, 90);
    mount(1'b1, 1'b1);
    hps_serve(13);
    fd_write(13'h0010, 8'h3C);
    check_eq("ro_dirty", 32'(dirty), 32'd0);
    push_rd_range(91, 103);
    track = 6'd7;
    hps_serve(13);
    fd_check("ro_reload_byte", 13'h0010, img_byte(91, 16));

    // Writable remount, out-of-track write, then a pending dirty sector.
    push_rd_range(91, 103);
    mount(1'b1, 1'b0);
    hps_serve(13);
    fd_write(6656, 8'h77);
    check_eq("oob_write_dirty", 32'(dirty), 32'd0);
    fd_write(13'h0402, 8'hC3);
    check_eq("sec2_dirty", 32'(dirty), 32'd1);
`ifdef FDD_IDLE_FLUSH_EN
    push_wr(93, 2, 8'hC3);
    hps_serve(1);
    cnt = 0;
    repeat (50) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr || cpu_wait) cnt++;
    end
    check_eq("idle_no_reload", 32'(cnt), 32'd0);
    check_eq("idle_dirty_clear", 32'(dirty), 32'd0);
    n_pre = 4;
`else
    cnt = 0;
    repeat (3 * IDLE_CYCLES) begin
      @(negedge clk_sys);
      if (sd_rd || sd_wr || cpu_wait) cnt++;
    end
    check_eq("no_idle_flush", 32'(cnt), 32'd0);
    check_eq("still_dirty", 32'(dirty), 32'd1);
    push_wr(93, 2, 8'hC3);
    n_pre = 5;
`endif

    // Track 8: let sectors 0..3 load, then reset during sector 4.
    push_rd_range(104, 107);
    track = 6'd8;
    hps_serve(n_pre);
    t = 0;
    while (!sd_rd && t < REQ_LIMIT) begin
      @(negedge clk_sys);
      t++;
    end
    check_eq("sec4_req_seen", 32'(t < REQ_LIMIT), 32'd1);
    check_eq("sec4_lba", sd_lba, 32'd108);
    sd_ack = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 10; i++) begin
      sd_buff_addr = 9'(i);
      sd_buff_dout = img_byte(108, i);
      sd_buff_wr   = 1'b1;
      @(negedge clk_sys);
    end
    check_eq("xfer_wait", 32'(cpu_wait), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check_eq("async_rst_wait", 32'(cpu_wait), 32'd0);
    check_eq("async_rst_rd", 32'(sd_rd), 32'd0);
    check_eq("async_rst_dirty", 32'(dirty), 32'd0);
    sd_buff_wr = 1'b0;
    sd_ack     = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    sd_ack       = 1'b1;
    sd_buff_addr = 9'd100;
    sd_buff_dout = 8'hEE;
    sd_buff_wr   = 1'b1;
    repeat (3) @(negedge clk_sys);
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    check_eq("late_ack_rd", 32'(sd_rd), 32'd0);
    check_eq("late_ack_wait", 32'(cpu_wait), 32'd0);
    fd_check("late_ack_no_write", 100, img_byte(104, 100));
    fd_check("sec4_untouched", 2048 + 100, img_byte(95, 100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fdd_track_cache.md
Name: fdd_track_cache

Overview:
- Single-track floppy cache between the Apple II disk controller track port and the HPS-style SD block channel 0 of the emu shell.
- Loads a full track of 13 x 512-byte sectors on a track change or image mount.
- Serves byte reads and writes from the controller, tracks dirty sectors, and writes dirty sectors back to the SD image before the track is replaced.
- Replaces the read-only track loader and the one-track dpram in the sim and emu top.

Parameters:
- SECTORS, 13, sectors per track; LBA = SECTORS*track + sector.
- TRACK_W, 6, width of the track number.
- IDLE_CYCLES, 1000000, clk_sys cycles without a controller write before an idle flush. Used only under FDD_IDLE_FLUSH_EN.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- track  in  TRACK_W  track requested by the controller.
- img_mounted  in  1  one-cycle pulse: an image was (un)mounted.
- img_size_nz  in  1  image size is nonzero; sampled on img_mounted.
- img_readonly  in  1  image is write-protected; sampled on img_mounted.
- fd_addr  in  13  byte address within the track, 0..6655.
- fd_we  in  1  controller write strobe.
- fd_din  in  8  controller write data.
- fd_dout  out  8  controller read data, 1-cycle latency.
- cpu_wait  out  1  stall request to the CPU.
- dirty  out  1  OR of the dirty mask; drives the disk LED.
- sd_lba  out  32  block address.
- sd_rd  out  1  read request.
- sd_wr  out  1  write request.
- sd_ack  in  1  HPS acknowledge; high for the whole 512-byte transfer.
- sd_buff_addr  in  9  byte index within the current transfer.
- sd_buff_dout  in  8  data from the SD card.
- sd_buff_wr  in  1  strobe for sd_buff_dout.
- sd_buff_din  out  8  data to the SD card, registered, 1-cycle latency from sd_buff_addr.

Behaviour:
- Storage: 8192x8 true dual-port RAM.
  - Port A (SD side) address is {sector[3:0], sd_buff_addr}.
  - Port B (controller side) address is fd_addr.
  - fd_addr values of 6656 and above read undefined data; writes to them are ignored.
- Internal state:
  - cur_track[TRACK_W]
  - mounted, ro, valid
  - dirty_mask[SECTORS]
  - sector[4]
  - idle counter
- Reset values (asynchronous): every register is 0, so sd_rd, sd_wr, cpu_wait and dirty are 0 and sd_lba is 0.
- States:
  - IDLE: cpu_wait=0.
    - fd_we sets the RAM byte. If ro=0 it also sets dirty_mask[fd_addr[12:9]].
    - Priority order:
      1. img_mounted: set mounted=img_size_nz, ro=img_readonly. Clear dirty_mask with no flush (old image is gone). If mounted, go to LOAD_REQ.
      2. mounted and (track!=cur_track or valid=0): if dirty_mask!=0, go to FLUSH_SCAN, else go to LOAD_REQ.
      3. Otherwise stay in IDLE.
    - When not mounted, track changes only update cur_track.
  - FLUSH_SCAN:
    - Set sector to the lowest set bit of dirty_mask and go to FLUSH_REQ.
    - If no bit is set, go to LOAD_REQ. From an idle flush, go to IDLE instead.
  - FLUSH_REQ: sd_lba=SECTORS*cur_track+sector, sd_wr=1. On sd_ack rising edge: sd_wr=0, go to FLUSH_XFER.
  - FLUSH_XFER: sd_buff_din follows RAM[{sector,sd_buff_addr}]. On sd_ack falling edge: clear dirty_mask[sector], go to FLUSH_SCAN.
  - LOAD_REQ:
    - On entry from IDLE: latch cur_track=track, sector=0, valid=0.
    - Then sd_lba=SECTORS*cur_track+sector, sd_rd=1.
    - On sd_ack rising edge: sd_rd=0, go to LOAD_XFER.
  - LOAD_XFER:
    - sd_buff_wr and sd_ack write sd_buff_dout to RAM.
    - On sd_ack falling edge:
      - If sector==SECTORS-1: valid=1, go to IDLE.
      - Else sector+1, go to LOAD_REQ.
- cpu_wait=1 in every state except IDLE, registered, and asserted the cycle after leaving IDLE. fd_we outside IDLE is ignored.
- A write accepted in the last IDLE cycle is included in the following flush.
- Track change during FLUSH or LOAD: the operation completes for the latched cur_track. IDLE then sees the mismatch and reloads.
- img_mounted outside IDLE: held pending in a 1-bit flag and serviced on return to IDLE. A load in progress completes first.
- sd_lba multiplier is computed at TRACK_W+4 bits and zero-extended to 32.
- sd_rd and sd_wr are never high together. Each is held until sd_ack rises.
- Reset mid-transfer: outputs clear immediately. A late sd_ack is ignored because the state is IDLE and valid=0.

Optional Feature:
- FDD_IDLE_FLUSH_EN
  - Defined: in IDLE with dirty_mask!=0 and mounted, a counter increments each cycle and clears on fd_we. At IDLE_CYCLES it enters FLUSH_SCAN tagged idle-flush, writes back all dirty sectors, and returns to IDLE with no reload. cpu_wait is asserted during the flush.
  - Undefined: dirty sectors are written only on a track change. Counter logic is absent.

Test Plan:
- Mount (img_mounted, img_size_nz=1), track=0 -> 13 sd_rd requests with lba 0..12. cpu_wait=1 throughout and drops after the 13th ack falls. fd_addr=512*k returns the first byte of block k.
- track 0->5, clean -> reads lba 65..77 only, with no sd_wr.
- On track 5: fd_we at fd_addr 0x0203 and 0x1801, then track=6 -> sd_wr lba 66 then 77 (sectors 1 and 12). sd_buff_din carries the written bytes at offsets 3 and 1. Then sd_rd lba 78..90. dirty returns to 0.
- Mount with img_readonly=1, write byte, change track -> no sd_wr, only reads.
- Assert reset_n=0 mid-LOAD_XFER of sector 4 -> sd_rd=0, cpu_wait=0, dirty=0 asynchronously. A further sd_ack toggle causes no RAM write.
- With FDD_IDLE_FLUSH_EN and IDLE_CYCLES=100, write sector 2 then idle 100 cycles -> one sd_wr at lba 13*track+2, no sd_rd, and IDLE with dirty=0.
